// File: rtl/latency_ram_if.sv
// Request/response bus for latency_ram. The err signal exists only when
// LATENCY_RAM_RANGE_CHECK_EN is defined.
interface latency_ram_if;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        response;
  logic [31:0] out;
`ifdef LATENCY_RAM_RANGE_CHECK_EN
  logic        err;

  modport master (output data, addr, wr, input response, out, err);
  modport slave  (input data, addr, wr, output response, out, err);
`else
  modport master (output data, addr, wr, input response, out);
  modport slave  (input data, addr, wr, output response, out);
`endif
endinterface

// File: rtl/latency_ram.sv
// Word RAM answering each request a fixed LATENCY edges after the request is seen.
// Optional macro LATENCY_RAM_RANGE_CHECK_EN adds err and out-of-range flagging.
//
// state | meaning
// IDLE  | no request since reset
// BUSY  | counting down towards completion of the latched request
// DONE  | request complete, response held while inputs are stable
module latency_ram #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input logic         clk,
  input logic         rst_n,
  latency_ram_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic        valid_q;
  logic [7:0]  cnt;
  logic        response_q;
  logic [31:0] out_q;
  logic        detect;
  logic        complete;
  logic        wr_en;
  logic [31:0] mem [DEPTH];

  // Any difference in the full request word, including upper address bits, is a new request.
  assign detect = !valid_q || (bus.data != data_q) || (bus.addr != addr_q) || (bus.wr != wr_q);

`ifdef LATENCY_RAM_RANGE_CHECK_EN
  logic oob_in;
  logic oob_q;
  logic err_q;

  assign oob_in  = (bus.addr >= 32'(DEPTH));
  assign wr_en   = detect && bus.wr && !oob_in;
  assign bus.err = err_q;
`else
  assign wr_en   = detect && bus.wr;
`endif

  assign bus.response = response_q;
  assign bus.out      = out_q;

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    if (detect) begin
      state_nxt = BUSY;
    end else begin
      case (state)
        BUSY: begin
          if (cnt == 8'd0) begin
            state_nxt = DONE;
            complete  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory shares the reset block only so that nothing commits while rst_n is low;
  // its contents are never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= 32'h0;
      addr_q     <= 32'h0;
      wr_q       <= 1'b0;
      valid_q    <= 1'b0;
      cnt        <= 8'd0;
      response_q <= 1'b0;
      out_q      <= 32'h0;
`ifdef LATENCY_RAM_RANGE_CHECK_EN
      oob_q      <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else if (detect) begin
      data_q     <= bus.data;
      addr_q     <= bus.addr;
      wr_q       <= bus.wr;
      valid_q    <= 1'b1;
      cnt        <= 8'(LATENCY - 1);
      response_q <= 1'b0;
      if (wr_en) mem[bus.addr[AW-1:0]] <= bus.data;
`ifdef LATENCY_RAM_RANGE_CHECK_EN
      oob_q      <= oob_in;
      err_q      <= 1'b0;
`endif
    end else if (complete) begin
      response_q <= 1'b1;
`ifdef LATENCY_RAM_RANGE_CHECK_EN
      err_q      <= oob_q;
      if (!wr_q) out_q <= oob_q ? 32'hDEAD_BEEF : mem[addr_q[AW-1:0]];
`else
      if (!wr_q) out_q <= mem[addr_q[AW-1:0]];
`endif
    end else if (state == BUSY) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule
